// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared states, field limits and blank masks for the time-set path
package clock_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'b00,
        SET_HOUR   = 2'b01,
        SET_MIN    = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    localparam logic [5:0] HOUR_MAX  = 6'd23;
    localparam logic [5:0] MIN_MAX   = 6'd59;
    localparam logic [3:0] MASK_HOUR = 4'b1100;
    localparam logic [3:0] MASK_MIN  = 4'b0011;

    // Values above the limit (e.g. a bad counter snapshot) also wrap to zero.
    function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max);
        return (value >= max) ? 6'd0 : value + 6'd1;
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// rtl/time_set_ctrl_if.sv - button, time snapshot and edit/load signals of the time-set stage
interface time_set_ctrl_if;
    logic       i_btn_mode;
    logic       i_btn_sel;
    logic       i_btn_up;
    logic [5:0] i_hour;
    logic [5:0] i_min;
    logic       o_modeSW;
    logic       o_set_en;
    logic       o_load;
    logic [5:0] o_set_hour;
    logic [5:0] o_set_min;
    logic [3:0] o_blank_mask;

    modport master (
        output i_btn_mode, i_btn_sel, i_btn_up, i_hour, i_min,
        input  o_modeSW, o_set_en, o_load, o_set_hour, o_set_min, o_blank_mask
    );

    modport slave (
        input  i_btn_mode, i_btn_sel, i_btn_up, i_hour, i_min,
        output o_modeSW, o_set_en, o_load, o_set_hour, o_set_min, o_blank_mask
    );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - synchronise a raw button and emit one pulse per accepted press
module btn_debounce #(
    parameter int DEBOUNCE_CNT = 100_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CNT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

    logic          sync1, sync2, sync_d, level;
    logic [CW-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync_d  <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            o_pulse <= 1'b0;
        end else begin
            sync1   <= i_btn;
            sync2   <= sync1;
            sync_d  <= sync2;
            o_pulse <= 1'b0;
            // Count only while the synced level differs from the accepted one and holds still.
            if (sync2 != sync_d || sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt     <= '0;
                level   <= sync2;
                o_pulse <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - button-driven set-time FSM with edit registers, load pulse and blink mask
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 100_000,
    parameter int BLINK_CNT    = 25_000_000
) (
    input  logic           i_clk,
    input  logic           i_reset,
    time_set_ctrl_if.slave bus
);
    localparam int BW = $clog2(BLINK_CNT) + 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CNT - 1);

    logic          pulse_mode, pulse_sel, pulse_up;
    state_t        state_q, state_n;
    logic          mode_sw_q, mode_sw_n, set_en_q, set_en_n, load_q, load_n;
    logic [5:0]    hour_q, hour_n, min_q, min_n;
    logic [BW-1:0] blink_q, blink_n;
    logic          phase_q, phase_n;

    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_mode (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(bus.i_btn_mode), .o_pulse(pulse_mode));
    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_sel (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(bus.i_btn_sel), .o_pulse(pulse_sel));
    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_up (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn(bus.i_btn_up), .o_pulse(pulse_up));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= RUN;
            mode_sw_q <= 1'b1;
            set_en_q  <= 1'b0;
            load_q    <= 1'b0;
            hour_q    <= '0;
            min_q     <= '0;
            blink_q   <= '0;
            phase_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            mode_sw_q <= mode_sw_n;
            set_en_q  <= set_en_n;
            load_q    <= load_n;
            hour_q    <= hour_n;
            min_q     <= min_n;
            blink_q   <= blink_n;
            phase_q   <= phase_n;
        end
    end

    // Priority mode > sel > up: the if/else chains drop lower pulses in the same cycle.
    always_comb begin
        state_n   = state_q;
        mode_sw_n = mode_sw_q;
        load_n    = 1'b0;
        hour_n    = hour_q;
        min_n     = min_q;
        case (state_q)
            RUN: begin
                if (pulse_mode) begin
                    mode_sw_n = ~mode_sw_q;
                end else if (pulse_sel) begin
                    hour_n    = bus.i_hour;
                    min_n     = bus.i_min;
                    mode_sw_n = 1'b1;
                    state_n   = SET_HOUR;
                end
            end
            SET_HOUR: begin
                if (pulse_mode)     state_n = RUN;
                else if (pulse_sel) state_n = SET_MIN;
                else if (pulse_up)  hour_n  = wrap_inc(hour_q, HOUR_MAX);
            end
            SET_MIN: begin
                if (pulse_mode) begin
                    state_n = RUN;
                end else if (pulse_sel) begin
                    state_n = RUN;
                    load_n  = 1'b1;
                end else if (pulse_up) begin
                    min_n = wrap_inc(min_q, MIN_MAX);
                end
            end
            default: state_n = RUN;
        endcase
        set_en_n = (state_n == SET_HOUR) || (state_n == SET_MIN);
    end

    // Blink restarts visible on every state entry and only runs while editing.
    always_comb begin
        blink_n = '0;
        phase_n = 1'b0;
        if (state_n == state_q && (state_q == SET_HOUR || state_q == SET_MIN)) begin
            if (blink_q == BLINK_LAST) begin
                phase_n = ~phase_q;
            end else begin
                blink_n = blink_q + 1'b1;
                phase_n = phase_q;
            end
        end
    end

    always_comb begin
        bus.o_blank_mask = 4'b0000;
        if (phase_q && state_q == SET_HOUR) bus.o_blank_mask = MASK_HOUR;
        if (phase_q && state_q == SET_MIN)  bus.o_blank_mask = MASK_MIN;
    end

    assign bus.o_modeSW   = mode_sw_q;
    assign bus.o_set_en   = set_en_q;
    assign bus.o_load     = load_q;
    assign bus.o_set_hour = hour_q;
    assign bus.o_set_min  = min_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - randomized button sequences checked against a behavioural set-time model
module tb_time_set_ctrl;
    localparam int DB = 4;
    localparam int BL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    time_set_ctrl_if bus ();

    time_set_ctrl #(.DEBOUNCE_CNT(DB), .BLINK_CNT(BL)) dut (
        .i_clk(clk), .i_reset(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    // Behavioural model: state 0 = normal display, 1 = editing hour, 2 = editing minute
    int m_state = 0, m_sw = 1, m_hour = 0, m_min = 0, m_loads = 0, m_load_h = 0, m_load_m = 0;

    int mon_loads = 0, mon_load_h = 0, mon_load_m = 0, mon_load_en = 0, mon_prev_en_at_load = 0;
    int toggles = 0;
    logic prev_en = 1'b0, prev_sw = 1'b1;

    always @(negedge clk) begin
        if (bus.o_load) begin
            mon_loads++;
            mon_load_h = bus.o_set_hour;
            mon_load_m = bus.o_set_min;
            mon_load_en = bus.o_set_en;
            mon_prev_en_at_load = prev_en;
        end
        if (bus.o_modeSW != prev_sw) toggles++;
        prev_en = bus.o_set_en;
        prev_sw = bus.o_modeSW;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_press(input bit m, input bit s, input bit u, input int hr, input int mn);
        if (m) begin
            if (m_state == 0) m_sw = 1 - m_sw;
            else m_state = 0;
        end else if (s) begin
            if (m_state == 0) begin
                m_hour = hr; m_min = mn; m_sw = 1; m_state = 1;
            end else if (m_state == 1) begin
                m_state = 2;
            end else begin
                m_state = 0; m_loads++; m_load_h = m_hour; m_load_m = m_min;
            end
        end else if (u) begin
            if (m_state == 1) m_hour = (m_hour + 1) % 24;
            if (m_state == 2) m_min = (m_min + 1) % 60;
        end
    endfunction

    task automatic press(input bit m, input bit s, input bit u, input int hold);
        @(negedge clk);
        bus.i_btn_mode = m; bus.i_btn_sel = s; bus.i_btn_up = u;
        repeat (hold) @(negedge clk);
        bus.i_btn_mode = 1'b0; bus.i_btn_sel = 1'b0; bus.i_btn_up = 1'b0;
        repeat (12) @(negedge clk);
        model_press(m, s, u, int'(bus.i_hour), int'(bus.i_min));
    endtask

    task automatic check_all(input string tag);
        check({tag, ".modeSW"}, int'(bus.o_modeSW), m_sw);
        check({tag, ".set_en"}, int'(bus.o_set_en), int'(m_state != 0));
        check({tag, ".loads"}, mon_loads, m_loads);
        if (m_state != 0) begin
            check({tag, ".hour"}, int'(bus.o_set_hour), m_hour);
            check({tag, ".min"}, int'(bus.o_set_min), m_min);
        end else begin
            check({tag, ".mask"}, int'(bus.o_blank_mask), 0);
        end
    endtask

    task automatic check_blink(input string tag, input int exp_mask);
        logic [3:0] prev, cur;
        int run = 0, bad = 0, changes = 0;
        bit first = 1'b1;
        @(negedge clk);
        prev = bus.o_blank_mask;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            cur = bus.o_blank_mask;
            if (cur != 4'd0 && int'(cur) != exp_mask) bad++;
            if (cur == prev) begin
                run++;
            end else begin
                changes++;
                if (!first) check({tag, ".run_len"}, run + 1, BL);
                first = 1'b0;
                run = 0;
            end
            prev = cur;
        end
        check({tag, ".bad_value"}, bad, 0);
        check({tag, ".enough_toggles"}, int'(changes >= 4), 1);
    endtask

    initial begin
        int t0, sel;
        bus.i_btn_mode = 1'b0; bus.i_btn_sel = 1'b0; bus.i_btn_up = 1'b0;
        bus.i_hour = 6'd0; bus.i_min = 6'd0;
        repeat (3) @(negedge clk);
        check("reset.modeSW", int'(bus.o_modeSW), 1);
        check("reset.set_en", int'(bus.o_set_en), 0);
        check("reset.load", int'(bus.o_load), 0);
        check("reset.hour", int'(bus.o_set_hour), 0);
        check("reset.min", int'(bus.o_set_min), 0);
        check("reset.mask", int'(bus.o_blank_mask), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        t0 = toggles;
        press(1, 0, 0, 20);
        check("t1.one_toggle", toggles - t0, 1);
        check_all("t1a");
        press(1, 0, 0, 12);
        check_all("t1b");

        t0 = toggles;
        @(negedge clk);
        bus.i_btn_mode = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_btn_mode = 1'b0;
        repeat (20) @(negedge clk);
        check("t2.no_toggle", toggles - t0, 0);
        check_all("t2");

        bus.i_hour = 6'd22; bus.i_min = 6'd58;
        press(0, 1, 0, 12); check_all("t3.enter");
        press(0, 0, 1, 12); press(0, 0, 1, 12); check_all("t3.hour_wrap");
        check("t3.hour_is_0", int'(bus.o_set_hour), 0);
        press(0, 1, 0, 12); press(0, 0, 1, 12); check_all("t3.min");
        check("t3.min_is_59", int'(bus.o_set_min), 59);
        t0 = mon_loads;
        press(0, 1, 0, 12); check_all("t3.commit");
        check("t3.one_load", mon_loads - t0, 1);
        check("t3.load_hour", mon_load_h, 0);
        check("t3.load_min", mon_load_m, 59);
        check("t3.set_en_at_load", mon_load_en, 0);
        check("t3.set_en_before_load", mon_prev_en_at_load, 1);

        press(0, 1, 0, 12);
        check_blink("t5.hour", 12);
        press(0, 1, 0, 12);
        check_blink("t5.min", 3);
        press(1, 0, 0, 12); check_all("t4.abort");

        press(0, 1, 0, 12); press(0, 1, 0, 12); check_all("t6.in_min");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6.set_en", int'(bus.o_set_en), 0);
        check("t6.modeSW", int'(bus.o_modeSW), 1);
        check("t6.mask", int'(bus.o_blank_mask), 0);
        check("t6.hour_cleared", int'(bus.o_set_hour), 0);
        m_state = 0; m_sw = 1; m_hour = 0; m_min = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all("t6.after");
        bus.i_hour = 6'd5; bus.i_min = 6'd7;
        press(0, 1, 0, 12); check_all("t6.reenter");
        press(1, 0, 0, 12);

        t0 = toggles;
        press(1, 0, 1, 12); check_all("t7.mode_up");
        press(1, 1, 0, 12); check_all("t7.mode_sel");
        check("t7.toggles", toggles - t0, 2);

        for (int i = 0; i < 40; i++) begin
            bus.i_hour = 6'($urandom_range(0, 23));
            bus.i_min = 6'($urandom_range(0, 59));
            sel = $urandom_range(0, 9);
            if (sel < 4)      press(0, 1, 0, 12);
            else if (sel < 8) press(0, 0, 1, 12);
            else              press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 12);
            check_all($sformatf("rand%0d", i));
        end
        check("rand.load_hour", mon_load_h, m_load_h);
        check("rand.load_min", mon_load_m, m_load_m);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
